// File: rtl/display_pkg.sv
// Shared glyph table and BCD/hex to 7-segment lookup for the display scanner.
package display_pkg;

    typedef logic [6:0] seg_t;

    // Segment and decimal-point drive level that lights an element.
    localparam logic SEG_ON = 1'b0;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic seg_t bcd_to_seg(input logic [3:0] code, input logic hex_en);
        seg_t res;
        case (code)
            4'h0:    res = SEG_0;
            4'h1:    res = SEG_1;
            4'h2:    res = SEG_2;
            4'h3:    res = SEG_3;
            4'h4:    res = SEG_4;
            4'h5:    res = SEG_5;
            4'h6:    res = SEG_6;
            4'h7:    res = SEG_7;
            4'h8:    res = SEG_8;
            4'h9:    res = SEG_9;
            4'hA:    res = hex_en ? SEG_A : SEG_BLANK;
            4'hB:    res = hex_en ? SEG_B : SEG_BLANK;
            4'hC:    res = hex_en ? SEG_C : SEG_BLANK;
            4'hD:    res = hex_en ? SEG_D : SEG_BLANK;
            4'hE:    res = hex_en ? SEG_E : SEG_BLANK;
            4'hF:    res = hex_en ? SEG_F : SEG_BLANK;
            default: res = SEG_BLANK;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph lookup for one digit, with a forced-blank override.
module seg7_glyph
    import display_pkg::*;
#(
    parameter int HEX_EN = 0
) (
    input  logic [3:0] code,
    input  logic       blank_digit,
    output seg_t       seg
);

    always_comb begin
        seg = blank_digit ? SEG_BLANK : bcd_to_seg(code, HEX_EN != 0);
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed N-digit 7-segment scanner with double-buffered frames,
// leading-zero blanking and a dead-time slot before each digit lights.
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000,
    parameter int HEX_EN   = 0,
    parameter int LZB_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
    logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    seg_t                  seg_q;
    logic                  dp_q, fs_q;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic                  slot_end, wrap;
    logic [N_DIGITS-1:0]   lz_blank;
    logic                  all_zero;
    logic [3:0]            cur_code;
    logic                  cur_blank, cur_dp;
    seg_t                  glyph;

    always_comb begin
        slot_end = (cnt_q == CNT_MAX);
        wrap     = slot_end && (idx_q == IDX_MAX);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        // A load in the wrap cycle still lands in pending and waits a frame.
        act_dig_d    = act_dig_q;
        act_dp_d     = act_dp_q;
        if (wrap && pend_valid_q) begin
            act_dig_d = pend_dig_q;
            act_dp_d  = pend_dp_q;
        end
        pend_dig_d   = load ? digits_in : pend_dig_q;
        pend_dp_d    = load ? dp_in : pend_dp_q;
        pend_valid_d = load || (pend_valid_q && !wrap);
    end

    // Blank digit i>0 when it and every more significant digit are zero.
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero && (act_dig_d[4*i +: 4] == 4'h0);
            lz_blank[i] = (LZB_EN != 0) && (i > 0) && all_zero;
        end
    end

    always_comb begin
        cur_code  = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        an_d      = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                cur_code  = act_dig_d[4*i +: 4];
                cur_blank = lz_blank[i];
                cur_dp    = act_dp_d[i];
                if (!blank && (cnt_d != '0)) begin
                    an_d[i] = 1'b0;
                end
            end
        end
    end

    seg7_glyph #(
        .HEX_EN(HEX_EN)
    ) u_glyph (
        .code       (cur_code),
        .blank_digit(cur_blank),
        .seg        (glyph)
    );

    // Outputs are registered from next-state so the cnt==0 slot is dark
    // while seg/dp already switch to the upcoming digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            dp_q         <= ~SEG_ON;
            an_q         <= '1;
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= glyph;
            dp_q         <= cur_dp ? SEG_ON : ~SEG_ON;
            an_q         <= an_d;
            fs_q         <= (cnt_d == '0) && (idx_d == '0);
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench: timeline model of loads/frames against two scanner builds.
module tb_bcd_display_scanner;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fs0, fs1;
    logic [3:0]  an0, an1;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: cycles since reset release and every load with its edge index.
    int          t = 0;
    int          nloads = 0;
    int          ld_k[1024];
    logic [15:0] ld_d[1024];
    logic [3:0]  ld_p[1024];
    logic        blank_m = 1'b0;

    always #5 clk = ~clk;

    bcd_display_scanner #(
        .N_DIGITS(4), .SCAN_DIV(4), .HEX_EN(0), .LZB_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .blank(blank), .seg(seg0), .dp(dp0), .an(an0), .frame_start(fs0)
    );

    bcd_display_scanner #(
        .N_DIGITS(4), .SCAN_DIV(4), .HEX_EN(1), .LZB_EN(1)
    ) dut_hex (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .blank(blank), .seg(seg1), .dp(dp1), .an(an1), .frame_start(fs1)
    );

    always @(posedge clk) begin
        blank_m <= blank;
        if (!rst_n) begin
            t      <= 0;
            nloads <= 0;
        end else begin
            t <= t + 1;
            if (load) begin
                ld_k[nloads] <= t + 1;
                ld_d[nloads] <= digits_in;
                ld_p[nloads] <= dp_in;
                nloads       <= nloads + 1;
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] c, input bit hex);
        case (c)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            4'd10: return hex ? 7'b0001000 : 7'b1111111;
            4'd11: return hex ? 7'b1100000 : 7'b1111111;
            4'd12: return hex ? 7'b0110001 : 7'b1111111;
            4'd13: return hex ? 7'b1000010 : 7'b1111111;
            4'd14: return hex ? 7'b0110000 : 7'b1111111;
            default: return hex ? 7'b0111000 : 7'b1111111;
        endcase
    endfunction

    // Frame f (starting at cycle 16f) shows the last load captured before edge 16f.
    function automatic exp_t model(input int tt, input bit hex);
        exp_t        e;
        logic [15:0] d;
        logic [3:0]  p;
        int          frame, idx, cnt;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fs = 1'b0;
        if (tt == 0) return e;
        frame = tt / 16;
        idx   = (tt / 4) % 4;
        cnt   = tt % 4;
        d = '0;
        p = '0;
        for (int i = 0; i < nloads; i++) begin
            if (ld_k[i] < 16 * frame) begin
                d = ld_d[i];
                p = ld_p[i];
            end
        end
        if (idx > 0 && (d >> (4 * idx)) == 16'h0) e.seg = 7'h7F;
        else e.seg = glyph(d[4*idx +: 4], hex);
        e.dp = ~p[idx];
        e.an = (blank_m || cnt == 0) ? 4'hF : ~(4'b0001 << idx);
        e.fs = (tt % 16 == 0);
        return e;
    endfunction

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({an0, seg0, dp0, fs0} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold: got an=%b seg=%b dp=%b fs=%b want 1111/1111111/1/0",
                         an0, seg0, dp0, fs0);
            end
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            e = model(t, 0);
            n_cmp++;
            if ({an0, seg0, dp0, fs0} !== e) begin
                n_fail++;
                $display("FAIL reset_release t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                         t, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
            end
            if (t == 1) begin
                n_cmp++;
                if (an0 !== 4'b1110 || seg0 !== 7'b0000001) begin
                    n_fail++;
                    $display("FAIL first_digit: got an=%b seg=%b want 1110/0000001", an0, seg0);
                end
            end
        end
    endtask

    task automatic test_load_scan();
        exp_t e;
        int   ts, last_fs;
        while (t % 16 != 6) @(negedge clk);
        pulse_load(16'h1234, 4'b0100);
        ts = (t / 16 + 1) * 16;
        last_fs = -1;
        while (t < ts + 32) begin
            @(negedge clk);
            e = model(t, 0);
            n_cmp++;
            if ({an0, seg0, dp0, fs0} !== e) begin
                n_fail++;
                $display("FAIL load_scan t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                         t, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
            end
            if (fs0 === 1'b1) begin
                if (last_fs >= 0) begin
                    n_cmp++;
                    if (t - last_fs !== 16) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d want 16", t - last_fs);
                    end
                end
                last_fs = t;
            end
            if (t == ts + 1) begin
                n_cmp++;
                if (an0 !== 4'b1110 || seg0 !== 7'b1001100) begin
                    n_fail++;
                    $display("FAIL slot0_digit4: got an=%b seg=%b want 1110/1001100", an0, seg0);
                end
            end
            if (t == ts + 9) begin
                n_cmp++;
                if (an0 !== 4'b1011 || dp0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL slot2_dp: got an=%b dp=%b want 1011/0", an0, dp0);
                end
            end
        end
    endtask

    task automatic test_leading_zeros();
        exp_t        e;
        int          ts;
        logic [15:0] vals[2];
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
        for (int v = 0; v < 2; v++) begin
            pulse_load(vals[v], 4'b0000);
            ts = (t / 16 + 1) * 16;
            while (t < ts + 16) begin
                @(negedge clk);
                e = model(t, 0);
                n_cmp++;
                if ({an0, seg0, dp0, fs0} !== e) begin
                    n_fail++;
                    $display("FAIL lzb t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                             t, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
                end
                if (t == ts + 5) begin
                    n_cmp++;
                    if (seg0 !== ((v == 0) ? 7'b0100100 : 7'b1111111)) begin
                        n_fail++;
                        $display("FAIL lzb_digit1 data=%h: got seg=%b", vals[v], seg0);
                    end
                end
                if (t == ts + 1) begin
                    n_cmp++;
                    if (seg0 !== 7'b0000001) begin
                        n_fail++;
                        $display("FAIL lzb_digit0 data=%h: got seg=%b want 0000001", vals[v], seg0);
                    end
                end
            end
        end
    endtask

    task automatic test_invalid_codes();
        exp_t e, eh;
        int   ts;
        pulse_load(16'h00A0, 4'b0000);
        ts = (t / 16 + 1) * 16;
        while (t < ts + 16) begin
            @(negedge clk);
            e  = model(t, 0);
            eh = model(t, 1);
            n_cmp += 2;
            if ({an0, seg0, dp0, fs0} !== e) begin
                n_fail++;
                $display("FAIL invalid_dec t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                         t, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
            end
            if ({an1, seg1, dp1, fs1} !== eh) begin
                n_fail++;
                $display("FAIL invalid_hex t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                         t, an1, seg1, dp1, fs1, eh.an, eh.seg, eh.dp, eh.fs);
            end
            if (t == ts + 5) begin
                n_cmp++;
                if (seg0 !== 7'b1111111 || seg1 !== 7'b0001000) begin
                    n_fail++;
                    $display("FAIL code_A: got dec=%b hex=%b want 1111111/0001000", seg0, seg1);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        exp_t e;
        int   ts, t0;
        while (t % 16 != 2) @(negedge clk);
        pulse_load(16'h1111, 4'b0000);
        ts = (t / 16 + 1) * 16;
        while (t != ts + 9) @(negedge clk);
        pulse_load(16'h2222, 4'b0000);
        while (t < ts + 32) begin
            @(negedge clk);
            e = model(t, 0);
            n_cmp++;
            if ({an0, seg0, dp0, fs0} !== e) begin
                n_fail++;
                $display("FAIL tear_free t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                         t, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
            end
            if (t == ts + 13 || t == ts + 29) begin
                n_cmp++;
                if (seg0 !== ((t == ts + 13) ? 7'b1001111 : 7'b0010010)) begin
                    n_fail++;
                    $display("FAIL tear_digit3 t=%0d: got seg=%b", t, seg0);
                end
            end
        end
        // Load coincident with the wrap edge: must wait one extra frame.
        while (t % 16 != 15) @(negedge clk);
        pulse_load(16'h3333, 4'b0000);
        t0 = t;
        while (t < t0 + 34) begin
            @(negedge clk);
            e = model(t, 0);
            n_cmp++;
            if ({an0, seg0, dp0, fs0} !== e) begin
                n_fail++;
                $display("FAIL wrap_load t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                         t, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
            end
            if (t == t0 + 13 || t == t0 + 29) begin
                n_cmp++;
                if (seg0 !== ((t == t0 + 13) ? 7'b0010010 : 7'b0000110)) begin
                    n_fail++;
                    $display("FAIL wrap_defer t=%0d: got seg=%b", t, seg0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        pulse_load(16'h5678, 4'b0001);
        pulse_load(16'h9012, 4'b1000);
        repeat (280) begin
            @(negedge clk);
            e = model(t, 0);
            n_cmp++;
            if ({an0, seg0, dp0, fs0} !== e) begin
                n_fail++;
                $display("FAIL random t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                         t, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
            end
            load      = ($urandom_range(0, 5) == 0);
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            if ($urandom_range(0, 24) == 0) blank = ~blank;
        end
        load  = 1'b0;
        blank = 1'b0;
        repeat (36) begin
            @(negedge clk);
            e = model(t, 0);
            n_cmp++;
            if ({an0, seg0, dp0, fs0} !== e) begin
                n_fail++;
                $display("FAIL random_drain t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                         t, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
            end
        end
    endtask

    task automatic test_blank_reset();
        exp_t e;
        while (t % 16 != 3) @(negedge clk);
        blank = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 9) blank = 1'b0;
            e = model(t, 0);
            n_cmp++;
            if ({an0, seg0, dp0, fs0} !== e) begin
                n_fail++;
                $display("FAIL blank t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                         t, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
            end
            if (k == 0) begin
                n_cmp++;
                if (an0 !== 4'hF) begin
                    n_fail++;
                    $display("FAIL blank_latency: got an=%b want 1111", an0);
                end
            end
        end
        while (t % 16 != 8) @(negedge clk);
        pulse_load(16'h9876, 4'b1111);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({an0, seg0, dp0, fs0} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL midscan_reset: got an=%b seg=%b dp=%b fs=%b want 1111/1111111/1/0",
                     an0, seg0, dp0, fs0);
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            e = model(t, 0);
            n_cmp++;
            if ({an0, seg0, dp0, fs0} !== e) begin
                n_fail++;
                $display("FAIL post_reset t=%0d: got an=%b seg=%b dp=%b fs=%b want %b/%b/%b/%b",
                         t, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary (compared=%0d)", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_scan();
        test_leading_zeros();
        test_invalid_codes();
        test_tear_free();
        test_back_to_back();
        test_blank_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
